// File: rtl/verisparse.sv
// Shared types and fixed-point helpers for the pursuit datapath correlation engine.
// Pure combinational helpers; no latency, no flow control.
package verisparse;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SCAN,
        DRAIN,
        DONE
    } vs_corr_state_t;

    // Helpers work at fixed maximum widths; callers size-cast in and out.
    localparam int VS_WMAX = 128;
    localparam int VS_FMAX = 64;

    // Clamp a wide signed value to an n-bit signed range.
    function automatic logic signed [VS_FMAX-1:0] vs_fp_sat(
        input logic signed [VS_WMAX-1:0] v,
        input int                        n
    );
        logic signed [VS_WMAX-1:0] hi;
        logic signed [VS_WMAX-1:0] lo;
        hi = (VS_WMAX'(1) << (n - 1)) - VS_WMAX'(1);
        lo = ~hi;
        if (v > hi)
            return hi[VS_FMAX-1:0];
        else if (v < lo)
            return lo[VS_FMAX-1:0];
        else
            return v[VS_FMAX-1:0];
    endfunction

    // Magnitude with one extra bit so the most-negative input does not wrap.
    function automatic logic [VS_FMAX:0] vs_fp_abs(
        input logic signed [VS_FMAX-1:0] v
    );
        logic signed [VS_FMAX:0] w;
        w = {v[VS_FMAX-1], v};
        return v[VS_FMAX-1] ? -w : w;
    endfunction

endpackage

// File: rtl/vs_fp_mac.sv
// Registered signed multiply feeding a full-precision accumulator, cleared on first element.
// Latency: 2 cycles from operands to acc; acc_done pulses with the last element; no backpressure.
module vs_fp_mac #(
    parameter int FP_N  = 32,
    parameter int ACC_W = 68
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_vld,
    input  logic                    in_first,
    input  logic                    in_last,
    input  logic signed [FP_N-1:0]  a,
    input  logic signed [FP_N-1:0]  b,
    output logic signed [ACC_W-1:0] acc,
    output logic                    acc_done
);

    logic signed [2*FP_N-1:0] prod;
    logic                     prod_vld;
    logic                     prod_first;
    logic                     prod_last;

    always_ff @(posedge clk) begin
        if (reset) begin
            prod       <= '0;
            prod_vld   <= 1'b0;
            prod_first <= 1'b0;
            prod_last  <= 1'b0;
        end else begin
            prod       <= (2*FP_N)'(a) * (2*FP_N)'(b);
            prod_vld   <= in_vld;
            prod_first <= in_first;
            prod_last  <= in_last;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc      <= '0;
            acc_done <= 1'b0;
        end else begin
            acc_done <= prod_vld & prod_last;
            if (prod_vld)
                acc <= prod_first ? ACC_W'(prod) : acc + ACC_W'(prod);
        end
    end

endmodule

// File: rtl/vs_atom_correlator.sv
// Caches the residual, streams all dictionary columns, reports the max-|corr| atom; done at S*(D+1)+4.
// No backpressure; VS_CORR_STREAM_EN adds a per-atom corr_* result stream.
module vs_atom_correlator
    import verisparse::*;
#(
    parameter int FP_N            = 32,
    parameter int FP_Q            = 15,
    parameter int SIGNAL_SIZE     = 16,
    parameter int DICTIONARY_SIZE = 64,
    parameter int SIG_AW          = 8,
    parameter int DICT_AW         = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic [SIG_AW-1:0]         y_read_addr,
    input  logic signed [FP_N-1:0]    y_read_data,
    output logic [DICT_AW-1:0]        dict_read_addr,
    input  logic signed [FP_N-1:0]    dict_read_data,
    output logic [((DICTIONARY_SIZE > 1) ? $clog2(DICTIONARY_SIZE) : 1)-1:0] best_index,
    output logic signed [FP_N-1:0]    best_value
`ifdef VS_CORR_STREAM_EN
    ,
    output logic                      corr_valid,
    output logic [((DICTIONARY_SIZE > 1) ? $clog2(DICTIONARY_SIZE) : 1)-1:0] corr_index,
    output logic signed [FP_N-1:0]    corr_value
`endif
);

    localparam int SW    = (SIGNAL_SIZE > 1) ? $clog2(SIGNAL_SIZE) : 1;
    localparam int IDX_W = (DICTIONARY_SIZE > 1) ? $clog2(DICTIONARY_SIZE) : 1;
    localparam int ACC_W = 2*FP_N + $clog2(SIGNAL_SIZE);

    vs_corr_state_t state;
    vs_corr_state_t state_nxt;

    logic [SW-1:0]           ld_cnt;
    logic [SW-1:0]           el_cnt;
    logic [IDX_W-1:0]        at_cnt;
    logic [DICT_AW-1:0]      dict_cnt;
    logic                    el_last;
    logic                    at_last;

    logic                    ld_vld;
    logic [SW-1:0]           ld_idx;
    logic signed [FP_N-1:0]  ybuf [SIGNAL_SIZE];
    logic signed [FP_N-1:0]  y_sel;

    logic                    s1_vld;
    logic                    s1_first;
    logic                    s1_last;
    logic signed [FP_N-1:0]  y_reg;

    logic signed [ACC_W-1:0] acc;
    logic                    acc_done;

    logic signed [ACC_W-1:0] shifted;
    logic signed [FP_N-1:0]  atom_val;
    logic [FP_N:0]           atom_abs;
    logic [IDX_W-1:0]        res_idx;
    logic                    res_last;
    logic                    take;
    logic [IDX_W-1:0]        run_idx;
    logic signed [FP_N-1:0]  run_val;
    logic [FP_N:0]           run_abs;
    logic [IDX_W-1:0]        nxt_idx;
    logic signed [FP_N-1:0]  nxt_val;
    logic [FP_N:0]           nxt_abs;

    assign el_last  = (el_cnt == SW'(SIGNAL_SIZE - 1));
    assign at_last  = (at_cnt == IDX_W'(DICTIONARY_SIZE - 1));
    assign res_last = (res_idx == IDX_W'(DICTIONARY_SIZE - 1));

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = LOAD;
            LOAD:    if (ld_cnt == SW'(SIGNAL_SIZE - 1)) state_nxt = SCAN;
            SCAN:    if (el_last && at_last) state_nxt = DRAIN;
            DRAIN:   if (acc_done && res_last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy           = (state != IDLE);
        done           = (state == DONE);
        y_read_addr    = (state == LOAD) ? SIG_AW'(ld_cnt) : '0;
        dict_read_addr = (state == SCAN) ? dict_cnt : '0;
    end

    always_ff @(posedge clk) begin
        if (reset || state == IDLE) begin
            ld_cnt   <= '0;
            el_cnt   <= '0;
            at_cnt   <= '0;
            dict_cnt <= '0;
        end else if (state == LOAD) begin
            ld_cnt <= ld_cnt + SW'(1);
        end else if (state == SCAN) begin
            dict_cnt <= dict_cnt + DICT_AW'(1);
            if (el_last) begin
                el_cnt <= '0;
                at_cnt <= at_cnt + IDX_W'(1);
            end else begin
                el_cnt <= el_cnt + SW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ld_vld <= 1'b0;
            ld_idx <= '0;
        end else begin
            ld_vld <= (state == LOAD);
            ld_idx <= ld_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (ld_vld)
            ybuf[ld_idx] <= y_read_data;
    end

    // With S=1 the only residual word lands on the same edge the scan first needs it.
    assign y_sel = (ld_vld && ld_idx == el_cnt) ? y_read_data : ybuf[el_cnt];

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_vld   <= 1'b0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
            y_reg    <= '0;
        end else begin
            s1_vld   <= (state == SCAN);
            s1_first <= (el_cnt == '0);
            s1_last  <= el_last;
            y_reg    <= y_sel;
        end
    end

    vs_fp_mac #(
        .FP_N  (FP_N),
        .ACC_W (ACC_W)
    ) u_mac (
        .clk      (clk),
        .reset    (reset),
        .in_vld   (s1_vld),
        .in_first (s1_first),
        .in_last  (s1_last),
        .a        (dict_read_data),
        .b        (y_reg),
        .acc      (acc),
        .acc_done (acc_done)
    );

    always_comb begin
        shifted  = acc >>> FP_Q;
        atom_val = FP_N'(vs_fp_sat(VS_WMAX'(shifted), FP_N));
        atom_abs = (FP_N+1)'(vs_fp_abs(VS_FMAX'(atom_val)));
        take     = (res_idx == '0) || (atom_abs > run_abs);
        nxt_idx  = take ? res_idx  : run_idx;
        nxt_val  = take ? atom_val : run_val;
        nxt_abs  = take ? atom_abs : run_abs;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            res_idx    <= '0;
            run_idx    <= '0;
            run_val    <= '0;
            run_abs    <= '0;
            best_index <= '0;
            best_value <= '0;
        end else if (state == IDLE) begin
            res_idx <= '0;
        end else if (acc_done) begin
            res_idx <= res_idx + IDX_W'(1);
            run_idx <= nxt_idx;
            run_val <= nxt_val;
            run_abs <= nxt_abs;
            if (res_last) begin
                best_index <= nxt_idx;
                best_value <= nxt_val;
            end
        end
    end

`ifdef VS_CORR_STREAM_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            corr_valid <= 1'b0;
            corr_index <= '0;
            corr_value <= '0;
        end else begin
            corr_valid <= acc_done;
            if (acc_done) begin
                corr_index <= res_idx;
                corr_value <= atom_val;
            end
        end
    end
`endif

endmodule

// File: tb/tb_vs_atom_correlator.sv
// Directed bench for vs_atom_correlator at S=4, D=3, Q15 with a registered-read RAM model.
module tb_vs_atom_correlator;

    localparam int S = 4;
    localparam int D = 3;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               start = 1'b0;
    logic               busy;
    logic               done;
    logic [7:0]         y_read_addr;
    logic signed [31:0] y_read_data = '0;
    logic [15:0]        dict_read_addr;
    logic signed [31:0] dict_read_data = '0;
    logic [1:0]         best_index;
    logic signed [31:0] best_value;
`ifdef VS_CORR_STREAM_EN
    logic               corr_valid;
    logic [1:0]         corr_index;
    logic signed [31:0] corr_value;
    int                 np;
    int                 cidx [3];
    int                 cval [3];
    int                 cdone [3];
`endif

    int n_chk = 0;
    int n_err = 0;

    logic signed [31:0] y_mem [S];
    logic signed [31:0] dict_mem [16];

    vs_atom_correlator #(
        .FP_N            (32),
        .FP_Q            (15),
        .SIGNAL_SIZE     (S),
        .DICTIONARY_SIZE (D),
        .SIG_AW          (8),
        .DICT_AW         (16)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .busy           (busy),
        .done           (done),
        .y_read_addr    (y_read_addr),
        .y_read_data    (y_read_data),
        .dict_read_addr (dict_read_addr),
        .dict_read_data (dict_read_data),
        .best_index     (best_index),
        .best_value     (best_value)
`ifdef VS_CORR_STREAM_EN
        ,
        .corr_valid     (corr_valid),
        .corr_index     (corr_index),
        .corr_value     (corr_value)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        y_read_data    <= y_mem[y_read_addr[1:0]];
        dict_read_data <= dict_mem[dict_read_addr[3:0]];
    end

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Each atom j: element 0 = aN, elements 1..3 = aNr.
    task automatic set_case(input int y0, input int yr,
                            input int a0, input int a0r,
                            input int a1, input int a1r,
                            input int a2, input int a2r);
        int av [3];
        int ar [3];
        av[0] = a0; av[1] = a1; av[2] = a2;
        ar[0] = a0r; ar[1] = a1r; ar[2] = a2r;
        y_mem[0] = y0;
        for (int i = 1; i < S; i++) y_mem[i] = yr;
        for (int k = 0; k < 16; k++) dict_mem[k] = '0;
        for (int j = 0; j < D; j++) begin
            dict_mem[j*S] = av[j];
            for (int i = 1; i < S; i++) dict_mem[j*S+i] = ar[j];
        end
    endtask

    // Called #1 after a rising edge; cycle 0 is the period in which start is first high.
    task automatic run_scan(input bit hold, output int done_at, output int ndone);
        done_at = -1;
        ndone   = 0;
`ifdef VS_CORR_STREAM_EN
        np = 0;
`endif
        start = 1'b1;
        for (int k = 0; k < 40; k++) begin
            if (k == 0)  chk("busy_c0", busy, 0);
            if (k == 1)  chk("busy_c1", busy, 1);
            if (k == 1)  chk("yaddr_c1", y_read_addr, 0);
            if (k == 4)  chk("yaddr_c4", y_read_addr, 3);
            if (k == 5)  chk("daddr_c5", dict_read_addr, 0);
            if (k == 16) chk("daddr_c16", dict_read_addr, 11);
            if (k == 17) chk("daddr_c17", dict_read_addr, 0);
            if (k == 21) chk("busy_c21", busy, 0);
            if (done) begin
                ndone++;
                if (done_at < 0) done_at = k;
                if (hold) start = 1'b0;
            end
`ifdef VS_CORR_STREAM_EN
            if (corr_valid) begin
                if (np < 3) begin
                    cidx[np]  = int'(corr_index);
                    cval[np]  = corr_value;
                    cdone[np] = int'(done);
                end
                np++;
            end
`endif
            @(posedge clk); #1;
            if (!hold && k == 0) start = 1'b0;
        end
    endtask

    initial begin
        int dat;
        int nd;

        set_case(0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_idx", best_index, 0);
        chk("rst_val", best_value, 0);
        chk("rst_yaddr", y_read_addr, 0);
        chk("rst_daddr", dict_read_addr, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Basic argmax: correlations 0.5, -0.75, 0.25
        set_case(32768, 0, 16384, 0, -24576, 0, 8192, 0);
        run_scan(1'b0, dat, nd);
        chk("basic_done_cyc", dat, 20);
        chk("basic_ndone", nd, 1);
        chk("basic_idx", best_index, 1);
        chk("basic_val", best_value, -24576);
`ifdef VS_CORR_STREAM_EN
        chk("strm_count", np, 3);
        chk("strm_idx0", cidx[0], 0);
        chk("strm_val0", cval[0], 16384);
        chk("strm_idx1", cidx[1], 1);
        chk("strm_val1", cval[1], -24576);
        chk("strm_idx2", cidx[2], 2);
        chk("strm_val2", cval[2], 8192);
        chk("strm_first_not_done", cdone[0], 0);
        chk("strm_last_with_done", cdone[2], 1);
`endif

        // Tie between atoms 0 and 2 keeps the lower index
        set_case(32768, 0, 16384, 0, 8192, 0, 16384, 0);
        run_scan(1'b0, dat, nd);
        chk("tie_idx", best_index, 0);
        chk("tie_val", best_value, 16384);

        // Positive saturation: 4 * 200 * 200 = 160000 > 65536
        set_case(6553600, 6553600, 0, 0, 6553600, 6553600, 0, 0);
        run_scan(1'b0, dat, nd);
        chk("sat_idx", best_index, 1);
        chk("sat_val", best_value, 32'sh7FFFFFFF);

        // Abort at cycle 10: best outputs must clear and no done appears
        set_case(32768, 0, 16384, 0, -24576, 0, 8192, 0);
        nd = 0;
        start = 1'b1;
        for (int k = 0; k <= 10; k++) begin
            if (done) nd++;
            if (k == 10) reset = 1'b1;
            @(posedge clk); #1;
            if (k == 0) start = 1'b0;
        end
        reset = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_idx", best_index, 0);
        chk("abort_val", best_value, 0);
        for (int k = 0; k < 6; k++) begin
            if (done) nd++;
            @(posedge clk); #1;
        end
        chk("abort_no_done", nd, 0);
        run_scan(1'b0, dat, nd);
        chk("restart_done_cyc", dat, 20);
        chk("restart_ndone", nd, 1);
        chk("restart_idx", best_index, 1);
        chk("restart_val", best_value, -24576);

        // -2^31 beats +2^31-1 on magnitude
        set_case(6553600, 6553600, -6553600, -6553600, 6553600, 6553600, 0, 0);
        run_scan(1'b0, dat, nd);
        chk("negsat_idx", best_index, 0);
        chk("negsat_val", best_value, 32'sh80000000);

        // Shift floors: -1 * 1 >> 15 is -1, not 0
        set_case(1, 0, -1, 0, 0, 0, 0, 0);
        run_scan(1'b0, dat, nd);
        chk("floor_idx", best_index, 0);
        chk("floor_val", best_value, -1);

        // All-zero dictionary
        set_case(32768, 32768, 0, 0, 0, 0, 0, 0);
        run_scan(1'b0, dat, nd);
        chk("zero_done_cyc", dat, 20);
        chk("zero_idx", best_index, 0);
        chk("zero_val", best_value, 0);

        // Start held high through the scan
        set_case(32768, 0, 16384, 0, -24576, 0, 8192, 0);
        run_scan(1'b1, dat, nd);
        chk("hold_done_cyc", dat, 20);
        chk("hold_ndone", nd, 1);
        chk("hold_idx", best_index, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
